pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_if.sv | 47 ++++
 rtl/pipeline_hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bus: ID source operands, per-stage destinations, branch events and pipeline controls.
// The stall_cnt member exists only when PIPE_STALL_CNT_EN is defined.
interface pipeline_hazard_ctrl_if;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        id_use_rs1;
   logic        id_use_rs2;
   logic [4:0]  ex_rd;
   logic [4:0]  mem_rd;
   logic [4:0]  wb_rd;
   logic        ex_rf_le;
   logic        mem_rf_le;
   logic        wb_rf_le;
   logic        ex_load;
   logic        br_valid;
   logic        br_annul;
   logic        pc_le;
   logic        npc_le;
   logic        ifid_le;
   logic        cu_nop;
   logic [1:0]  fwd_a;
   logic [1:0]  fwd_b;
`ifdef PIPE_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   // The pipeline datapath is the master; the hazard controller is the slave.
   modport master (
`ifdef PIPE_STALL_CNT_EN
      input  stall_cnt,
`endif
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
      output ex_rd, mem_rd, wb_rd, ex_rf_le, mem_rf_le, wb_rf_le,
      output ex_load, br_valid, br_annul,
      input  pc_le, npc_le, ifid_le, cu_nop, fwd_a, fwd_b
   );

   modport slave (
`ifdef PIPE_STALL_CNT_EN
      output stall_cnt,
`endif
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
      input  ex_rd, mem_rd, wb_rd, ex_rf_le, mem_rf_le, wb_rf_le,
      input  ex_load, br_valid, br_annul,
      output pc_le, npc_le, ifid_le, cu_nop, fwd_a, fwd_b
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall and delay-slot annul bubbles.
// Optional feature: define PIPE_STALL_CNT_EN to add a saturating bubble counter (stall_cnt).
module pipeline_hazard_ctrl (
   input logic                   clk,
   input logic                   clr,
   pipeline_hazard_ctrl_if.slave hz
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LD_STALL = 2'd1,
      ANNUL    = 2'd2
   } state_t;

   state_t r_state;
   state_t w_nextState;
   logic   r_pending;
   logic   w_nextPending;
   logic   w_loadUse;
   logic   w_brAnnul;
   logic   w_annulDue;
   logic   w_holdFetch;
   logic   w_bubble;
   logic   w_src1Hit;
   logic   w_src2Hit;

   // Nearest producing stage wins; register 0 is hard-wired and never forwarded.
   function automatic logic [1:0] fwdSel(
      input logic [4:0] rs,
      input logic       readsSrc,
      input logic [4:0] exRd,
      input logic       exLe,
      input logic [4:0] memRd,
      input logic       memLe,
      input logic [4:0] wbRd,
      input logic       wbLe
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (readsSrc && (rs != 5'd0)) begin
         if (exLe && (exRd == rs)) begin
            sel = 2'b01;
         end else if (memLe && (memRd == rs)) begin
            sel = 2'b10;
         end else if (wbLe && (wbRd == rs)) begin
            sel = 2'b11;
         end
      end
      return sel;
   endfunction

   always_comb begin
      hz.fwd_a = fwdSel(hz.id_rs1, hz.id_use_rs1, hz.ex_rd, hz.ex_rf_le,
                        hz.mem_rd, hz.mem_rf_le, hz.wb_rd, hz.wb_rf_le);
      hz.fwd_b = fwdSel(hz.id_rs2, hz.id_use_rs2, hz.ex_rd, hz.ex_rf_le,
                        hz.mem_rd, hz.mem_rf_le, hz.wb_rd, hz.wb_rf_le);
   end

   always_comb begin
      w_src1Hit = hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd);
      w_src2Hit = hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd);
      w_loadUse = hz.ex_load && hz.ex_rf_le && (hz.ex_rd != 5'd0) && (w_src1Hit || w_src2Hit);
      w_brAnnul = hz.br_valid && hz.br_annul;
      w_annulDue = r_pending || w_brAnnul;
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         r_state   <= RUN;
         r_pending <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_pending <= w_nextPending;
      end
   end

   // A stall defers any annul into the pending bit; entering ANNUL always consumes it.
   always_comb begin
      w_nextState   = r_state;
      w_nextPending = r_pending;
      w_holdFetch   = 1'b0;
      w_bubble      = 1'b0;
      case (r_state)
         RUN: begin
            if (w_loadUse) begin
               w_holdFetch   = 1'b1;
               w_bubble      = 1'b1;
               w_nextState   = LD_STALL;
               w_nextPending = w_annulDue;
            end else if (w_annulDue) begin
               w_nextState   = ANNUL;
               w_nextPending = 1'b0;
            end
         end
         LD_STALL: begin
            if (w_annulDue) begin
               w_nextState   = ANNUL;
               w_nextPending = 1'b0;
            end else begin
               w_nextState   = RUN;
            end
         end
         ANNUL: begin
            w_bubble = 1'b1;
            if (w_annulDue) begin
               w_nextState   = ANNUL;
               w_nextPending = 1'b0;
            end else begin
               w_nextState   = RUN;
            end
         end
         default: begin
            w_nextState   = RUN;
            w_nextPending = 1'b0;
         end
      endcase
   end

   // While clr is low the front end keeps loading but the control bus is held as a bubble.
   always_comb begin
      hz.pc_le   = clr ? ~w_holdFetch : 1'b1;
      hz.npc_le  = clr ? ~w_holdFetch : 1'b1;
      hz.ifid_le = clr ? ~w_holdFetch : 1'b1;
      hz.cu_nop  = clr ? w_bubble     : 1'b1;
   end

`ifdef PIPE_STALL_CNT_EN
   logic [15:0] r_stallCnt;

   always_ff @(posedge clk) begin
      if (!clr) begin
         r_stallCnt <= 16'd0;
      end else if (hz.cu_nop && (r_stallCnt != 16'hFFFF)) begin
         r_stallCnt <= r_stallCnt + 16'd1;
      end
   end

   assign hz.stall_cnt = r_stallCnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed vectors, literal checks and a per-cycle model.
// Build with PIPE_STALL_CNT_EN defined to also exercise the bubble counter.
module tb_pipeline_hazard_ctrl;

   typedef struct packed {
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic [4:0] exRd;
      logic       exLe;
      logic       exLoad;
      logic [4:0] memRd;
      logic       memLe;
      logic [4:0] wbRd;
      logic       wbLe;
      logic       brV;
      logic       brA;
   } vec_t;

   typedef enum {HOLD, SQUASH} slot_t;

   logic clk;
   logic clr;
   logic started;
   int   checks;
   int   errors;

   pipeline_hazard_ctrl_if bus ();

   pipeline_hazard_ctrl dut (
      .clk (clk),
      .clr (clr),
      .hz  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(
      input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
      input logic [4:0] exRd, input logic exLe, input logic exLoad,
      input logic [4:0] memRd, input logic memLe, input logic [4:0] wbRd, input logic wbLe,
      input logic brV, input logic brA
   );
      vec_t v;
      v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
      v.exRd = exRd; v.exLe = exLe; v.exLoad = exLoad;
      v.memRd = memRd; v.memLe = memLe; v.wbRd = wbRd; v.wbLe = wbLe;
      v.brV = brV; v.brA = brA;
      return v;
   endfunction

   // Forwarding source is the youngest stage writing the register; r0 never forwards.
   function automatic logic [1:0] fwdModel(input logic [4:0] rs, input logic reads);
      logic [4:0] rds [3];
      logic       les [3];
      rds[0] = bus.ex_rd;  les[0] = bus.ex_rf_le;
      rds[1] = bus.mem_rd; les[1] = bus.mem_rf_le;
      rds[2] = bus.wb_rd;  les[2] = bus.wb_rf_le;
      for (int s = 0; s < 3; s++) begin
         if (reads && rs != 0 && les[s] && rds[s] == rs) return 2'(s + 1);
      end
      return 2'b00;
   endfunction

   // Drive one cycle of inputs shortly after the rising edge.
   task automatic applyStimulus(input logic c, input vec_t v);
      @(posedge clk);
      #1;
      clr            = c;
      bus.id_rs1     = v.rs1;
      bus.id_use_rs1 = v.u1;
      bus.id_rs2     = v.rs2;
      bus.id_use_rs2 = v.u2;
      bus.ex_rd      = v.exRd;
      bus.ex_rf_le   = v.exLe;
      bus.ex_load    = v.exLoad;
      bus.mem_rd     = v.memRd;
      bus.mem_rf_le  = v.memLe;
      bus.wb_rd      = v.wbRd;
      bus.wb_rf_le   = v.wbLe;
      bus.br_valid   = v.brV;
      bus.br_annul   = v.brA;
   endtask

   task automatic checkOutput(input string name, input logic expEn, input logic expNop,
                              input logic [1:0] expFa, input logic [1:0] expFb);
      #1;
      checks++;
      if (bus.pc_le !== expEn || bus.npc_le !== expEn || bus.ifid_le !== expEn ||
          bus.cu_nop !== expNop || bus.fwd_a !== expFa || bus.fwd_b !== expFb) begin
         errors++;
         $display("[TB] FAIL %s: got en=%b%b%b nop=%b fa=%b fb=%b, required en=%b nop=%b fa=%b fb=%b",
                  name, bus.pc_le, bus.npc_le, bus.ifid_le, bus.cu_nop, bus.fwd_a, bus.fwd_b,
                  expEn, expNop, expFa, expFb);
      end
   endtask

`ifdef PIPE_STALL_CNT_EN
   task automatic checkCount(input string name, input logic [15:0] expCnt);
      checks++;
      if (bus.stall_cnt !== expCnt) begin
         errors++;
         $display("[TB] FAIL %s: got stall_cnt=%h, required %h", name, bus.stall_cnt, expCnt);
      end
   endtask
`endif

   // Model: a queue of forced cycles owed by earlier events (HOLD after a stall, SQUASH after an annul).
   slot_t       owed [$];
   int unsigned modelCnt;

   always @(negedge clk) begin
      if (started) begin
         logic       expEn;
         logic       expNop;
         logic [1:0] expFa;
         logic [1:0] expFb;
         logic       loadUse;
         logic       squashQueued;
         slot_t      slot;

         expFa = fwdModel(bus.id_rs1, bus.id_use_rs1);
         expFb = fwdModel(bus.id_rs2, bus.id_use_rs2);
         loadUse = bus.ex_load && bus.ex_rf_le && bus.ex_rd != 0 &&
                   ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) ||
                    (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));

         if (!clr) begin
            expEn  = 1'b1;
            expNop = 1'b1;
         end else if (owed.size() > 0) begin
            slot   = owed.pop_front();
            expEn  = 1'b1;
            expNop = (slot == SQUASH);
         end else if (loadUse) begin
            expEn  = 1'b0;
            expNop = 1'b1;
            owed.push_back(HOLD);
         end else begin
            expEn  = 1'b1;
            expNop = 1'b0;
         end

         if (!clr) begin
            owed.delete();
         end else if (bus.br_valid && bus.br_annul) begin
            squashQueued = 1'b0;
            foreach (owed[i]) if (owed[i] == SQUASH) squashQueued = 1'b1;
            if (!squashQueued) owed.push_back(SQUASH);
         end

         checks++;
         if (bus.pc_le !== expEn || bus.npc_le !== expEn || bus.ifid_le !== expEn ||
             bus.cu_nop !== expNop || bus.fwd_a !== expFa || bus.fwd_b !== expFb) begin
            errors++;
            $display("[TB] FAIL model_cycle t=%0t: got en=%b%b%b nop=%b fa=%b fb=%b, required en=%b nop=%b fa=%b fb=%b",
                     $time, bus.pc_le, bus.npc_le, bus.ifid_le, bus.cu_nop, bus.fwd_a, bus.fwd_b,
                     expEn, expNop, expFa, expFb);
         end

`ifdef PIPE_STALL_CNT_EN
         checks++;
         if (bus.stall_cnt !== 16'(modelCnt)) begin
            errors++;
            $display("[TB] FAIL model_cnt t=%0t: got stall_cnt=%h, required %h",
                     $time, bus.stall_cnt, 16'(modelCnt));
         end
`endif
         if (!clr) modelCnt = 0;
         else if (expNop && modelCnt < 32'hFFFF) modelCnt++;
      end
   end

   initial begin
      vec_t idle;
      vec_t ldUse;
      vec_t ldUseBr;
      vec_t brAn;

      checks   = 0;
      errors   = 0;
      started  = 1'b0;
      modelCnt = 0;
      clr      = 1'b0;
      idle     = mk(0,0,0,0, 0,0,0, 0,0, 0,0, 0,0);
      ldUse    = mk(3,1,0,0, 3,1,1, 0,0, 0,0, 0,0);
      ldUseBr  = mk(3,1,0,0, 3,1,1, 0,0, 0,0, 1,1);
      brAn     = mk(0,0,0,0, 0,0,0, 0,0, 0,0, 1,1);

      applyStimulus(1'b0, idle);  checkOutput("reset_outputs", 1, 1, 2'b00, 2'b00);
      applyStimulus(1'b0, idle);
      started = 1'b1;

      // Forwarding priority and register-0 exclusion.
      applyStimulus(1'b1, mk(5,1,0,0, 5,1,0, 0,0, 0,0, 0,0));   checkOutput("fwd_ex", 1, 0, 2'b01, 2'b00);
      applyStimulus(1'b1, mk(0,1,7,1, 0,1,0, 7,1, 7,1, 0,0));   checkOutput("fwd_mem_over_wb_r0", 1, 0, 2'b00, 2'b10);
      applyStimulus(1'b1, mk(9,1,9,0, 4,1,0, 6,1, 9,1, 0,0));   checkOutput("fwd_wb_unused", 1, 0, 2'b11, 2'b00);
      applyStimulus(1'b1, mk(12,1,12,1, 12,0,0, 12,1, 12,1, 0,0)); checkOutput("fwd_ex_noLe", 1, 0, 2'b10, 2'b10);

      // Load-use stall, including the LD_STALL cycle ignoring a still-present hazard.
      applyStimulus(1'b1, ldUse);  checkOutput("lu_stall", 0, 1, 2'b01, 2'b00);
      applyStimulus(1'b1, ldUse);  checkOutput("lu_hold", 1, 0, 2'b01, 2'b00);
      applyStimulus(1'b1, idle);   checkOutput("lu_run", 1, 0, 2'b00, 2'b00);
      applyStimulus(1'b1, mk(0,1,0,0, 0,1,1, 0,0, 0,0, 0,0)); checkOutput("lu_r0", 1, 0, 2'b00, 2'b00);
      applyStimulus(1'b1, mk(1,0,8,1, 8,1,1, 0,0, 0,0, 0,0)); checkOutput("lu_rs2", 0, 1, 2'b00, 2'b01);
      applyStimulus(1'b1, idle);   checkOutput("lu_rs2_hold", 1, 0, 2'b00, 2'b00);
      applyStimulus(1'b1, mk(8,0,8,0, 8,1,1, 0,0, 0,0, 0,0)); checkOutput("lu_unused", 1, 0, 2'b00, 2'b00);

      // Annulling and non-annulling branches.
      applyStimulus(1'b1, brAn);   checkOutput("br_same_cycle", 1, 0, 2'b00, 2'b00);
      applyStimulus(1'b1, idle);   checkOutput("br_annul", 1, 1, 2'b00, 2'b00);
      applyStimulus(1'b1, idle);   checkOutput("br_run", 1, 0, 2'b00, 2'b00);
      applyStimulus(1'b1, mk(0,0,0,0, 0,0,0, 0,0, 0,0, 1,0)); checkOutput("br_noannul", 1, 0, 2'b00, 2'b00);
      applyStimulus(1'b1, idle);   checkOutput("br_noannul_next", 1, 0, 2'b00, 2'b00);

      // Coincident load-use and annul, starting from a fresh reset.
      applyStimulus(1'b0, idle);   checkOutput("reset_mid", 1, 1, 2'b00, 2'b00);
      applyStimulus(1'b1, ldUseBr); checkOutput("co_stall", 0, 1, 2'b01, 2'b00);
      applyStimulus(1'b1, idle);   checkOutput("co_hold", 1, 0, 2'b00, 2'b00);
      applyStimulus(1'b1, idle);   checkOutput("co_annul", 1, 1, 2'b00, 2'b00);
      applyStimulus(1'b1, idle);   checkOutput("co_run", 1, 0, 2'b00, 2'b00);
`ifdef PIPE_STALL_CNT_EN
      checkCount("cnt_after_co", 16'd2);
`endif

      // Reset during LD_STALL drops the pending annul.
      applyStimulus(1'b1, ldUseBr); checkOutput("rs_stall", 0, 1, 2'b01, 2'b00);
      applyStimulus(1'b0, idle);   checkOutput("rs_reset", 1, 1, 2'b00, 2'b00);
      applyStimulus(1'b1, idle);   checkOutput("rs_release", 1, 0, 2'b00, 2'b00);
      applyStimulus(1'b1, idle);   checkOutput("rs_release2", 1, 0, 2'b00, 2'b00);

      // Back-to-back annuls and an annul arriving during LD_STALL.
      applyStimulus(1'b1, brAn);   checkOutput("chain_br", 1, 0, 2'b00, 2'b00);
      applyStimulus(1'b1, brAn);   checkOutput("chain_annul1", 1, 1, 2'b00, 2'b00);
      applyStimulus(1'b1, ldUse);  checkOutput("chain_annul2_nolu", 1, 1, 2'b01, 2'b00);
      applyStimulus(1'b1, idle);   checkOutput("chain_run", 1, 0, 2'b00, 2'b00);
      applyStimulus(1'b1, ldUse);  checkOutput("late_stall", 0, 1, 2'b01, 2'b00);
      applyStimulus(1'b1, brAn);   checkOutput("late_hold", 1, 0, 2'b00, 2'b00);
      applyStimulus(1'b1, idle);   checkOutput("late_annul", 1, 1, 2'b00, 2'b00);
      applyStimulus(1'b1, idle);   checkOutput("late_run", 1, 0, 2'b00, 2'b00);

`ifdef PIPE_STALL_CNT_EN
      // Continuous annuls produce one bubble per cycle, enough to saturate the counter.
      applyStimulus(1'b0, idle);
      for (int i = 0; i < 65540; i++) applyStimulus(1'b1, brAn);
      applyStimulus(1'b1, idle);
      applyStimulus(1'b1, idle);
      #1;
      checkCount("cnt_saturated", 16'hFFFF);
`endif

      applyStimulus(1'b1, idle);
      @(posedge clk);
      #1;
      started = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
